// File: rtl/if_id_pipeline_ctrl_if.sv
// Handshake/control bundle between the IF/ID sequencing controller and its
// environment (hazard unit, branch resolution, PC and IF/ID registers).
interface if_id_pipeline_ctrl_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
);
  logic                  start;
  logic                  fetch_ready;
  logic                  load_use_hazard;
  logic                  ext_stall;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  inst_buffer_full;
  logic                  inst_buffer_empty;
  logic                  pc_stall;
  logic                  id_stall;
  logic                  id_flush;
  logic                  pc_load;
  logic [ADDR_WIDTH-1:0] pc_load_addr;
  logic                  id_valid;
  logic [2:0]            state;
  logic [CNT_WIDTH-1:0]  stall_cycles;
  logic [CNT_WIDTH-1:0]  flush_count;

  modport master (
    input  start, fetch_ready, load_use_hazard, ext_stall, redirect,
           redirect_pc, inst_buffer_full, inst_buffer_empty,
    output pc_stall, id_stall, id_flush, pc_load, pc_load_addr, id_valid,
           state, stall_cycles, flush_count
  );

  modport slave (
    output start, fetch_ready, load_use_hazard, ext_stall, redirect,
           redirect_pc, inst_buffer_full, inst_buffer_empty,
    input  pc_stall, id_stall, id_flush, pc_load, pc_load_addr, id_valid,
           state, stall_cycles, flush_count
  );
endinterface

// File: rtl/if_id_pipeline_ctrl.sv
// IF->ID boundary sequencer: idle/refill/run/stall/flush control of the PC and
// IF/ID register, redirect handling and saturating stall/flush counters.
module if_id_pipeline_ctrl #(
  parameter int ADDR_WIDTH   = 64,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  if_id_pipeline_ctrl_if.master   ctrl
);

  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FCW-1:0]       FCNT_LOAD = FCW'(FLUSH_CYCLES);
  localparam logic [FCW-1:0]       FCNT_ONE  = FCW'(32'd1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(32'd1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REFILL = 3'd1,
    ST_RUN    = 3'd2,
    ST_STALL  = 3'd3,
    ST_FLUSH  = 3'd4
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [FCW-1:0]        flush_cnt_r;
  logic                  pc_load_r;
  logic [ADDR_WIDTH-1:0] pc_load_addr_r;
  logic [CNT_WIDTH-1:0]  stall_cycles_r;
  logic [CNT_WIDTH-1:0]  flush_count_r;

  logic stall_term_s;
  logic accept_s;
  logic pc_stall_s;
  logic id_stall_s;
  logic id_flush_s;
  logic id_valid_s;

  // A full instruction buffer stalls even when fetch data is ready.
  assign stall_term_s = ctrl.load_use_hazard | ctrl.ext_stall |
                        ctrl.inst_buffer_full | ~ctrl.fetch_ready;

  // Next-state and combinational stall/flush outputs; redirect beats every stall term.
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    pc_stall_s = 1'b1;
    id_stall_s = 1'b1;
    id_flush_s = 1'b0;
    id_valid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ctrl.start) begin
          state_s = ST_REFILL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REFILL: begin
        pc_stall_s = 1'b0;
        id_stall_s = 1'b0;
        if (ctrl.redirect) begin
          accept_s = 1'b1;
          state_s  = ST_FLUSH;
        end else if (ctrl.fetch_ready) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_REFILL;
        end
      end
      ST_RUN, ST_STALL: begin
        pc_stall_s = stall_term_s & ~ctrl.redirect;
        id_stall_s = stall_term_s & ~ctrl.redirect;
        id_valid_s = ~ctrl.inst_buffer_empty;
        if (ctrl.redirect) begin
          accept_s = 1'b1;
          state_s  = ST_FLUSH;
        end else if (stall_term_s) begin
          state_s = ST_STALL;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        pc_stall_s = 1'b0;
        id_stall_s = 1'b0;
        id_flush_s = 1'b1;
        if (ctrl.redirect) begin
          accept_s = 1'b1;
          state_s  = ST_FLUSH;
        end else if (flush_cnt_r <= FCNT_ONE) begin
          state_s = ST_REFILL;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register, flush sequencing and redirect target capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      flush_cnt_r    <= '0;
      pc_load_r      <= 1'b0;
      pc_load_addr_r <= '0;
    end else begin
      state_r   <= state_s;
      pc_load_r <= accept_s;
      if (accept_s) begin
        flush_cnt_r    <= FCNT_LOAD;
        pc_load_addr_r <= ctrl.redirect_pc;
      end else if ((state_r == ST_FLUSH) && (flush_cnt_r != '0)) begin
        flush_cnt_r <= flush_cnt_r - FCNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_r <= '0;
      flush_count_r  <= '0;
    end else begin
      if ((state_r == ST_STALL) && !(&stall_cycles_r)) begin
        stall_cycles_r <= stall_cycles_r + CNT_ONE;
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
      if (accept_s && !(&flush_count_r)) begin
        flush_count_r <= flush_count_r + CNT_ONE;
      end else begin
        flush_count_r <= flush_count_r;
      end
    end
  end

  assign ctrl.pc_stall     = pc_stall_s;
  assign ctrl.id_stall     = id_stall_s;
  assign ctrl.id_flush     = id_flush_s;
  assign ctrl.id_valid     = id_valid_s;
  assign ctrl.pc_load      = pc_load_r;
  assign ctrl.pc_load_addr = pc_load_addr_r;
  assign ctrl.state        = state_r;
  assign ctrl.stall_cycles = stall_cycles_r;
  assign ctrl.flush_count  = flush_count_r;

endmodule

// File: tb/tb_if_id_pipeline_ctrl.sv
// Bench for if_id_pipeline_ctrl: directed test-plan steps followed by random
// stimulus, all checked against a cycle-timeline reference model.
module tb_if_id_pipeline_ctrl;
  localparam int AW  = 64;
  localparam int FC  = 2;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_id_pipeline_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  if_id_pipeline_ctrl #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus.master)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase number, cycle index of the latest accepted redirect.
  int          m_state;
  int          cyc;
  int          last_acc;
  logic [63:0] m_addr;
  int          m_stalls;
  int          m_flushes;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state   = 0;
    last_acc  = -100;
    m_addr    = 64'd0;
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  task automatic check_all();
    logic s, e_stall, e_valid, e_flush, e_load;
    s = bus.load_use_hazard | bus.ext_stall | bus.inst_buffer_full | ~bus.fetch_ready;
    e_stall = 1'b1; e_valid = 1'b0; e_flush = 1'b0;
    case (m_state)
      1: e_stall = 1'b0;
      2, 3: begin
        e_stall = s & ~bus.redirect;
        e_valid = ~bus.inst_buffer_empty;
      end
      4: begin
        e_stall = 1'b0;
        e_flush = 1'b1;
      end
      default: e_stall = 1'b1;
    endcase
    e_load = (m_state == 4) && (cyc == last_acc + 1);
    chk("state",        64'(bus.state),        64'(m_state));
    chk("pc_stall",     64'(bus.pc_stall),     64'(e_stall));
    chk("id_stall",     64'(bus.id_stall),     64'(e_stall));
    chk("id_flush",     64'(bus.id_flush),     64'(e_flush));
    chk("pc_load",      64'(bus.pc_load),      64'(e_load));
    chk("pc_load_addr", 64'(bus.pc_load_addr), m_addr);
    chk("id_valid",     64'(bus.id_valid),     64'(e_valid));
    chk("stall_cycles", 64'(bus.stall_cycles), 64'(m_stalls));
    chk("flush_count",  64'(bus.flush_count),  64'(m_flushes));
  endtask

  // Called at posedge+1 with inputs set: check mid-cycle, then advance one edge.
  task automatic tick();
    logic s;
    int   nxt;
    #3;
    check_all();
    s = bus.load_use_hazard | bus.ext_stall | bus.inst_buffer_full | ~bus.fetch_ready;
    if (m_state == 3) m_stalls = (m_stalls < SAT) ? m_stalls + 1 : SAT;
    if (bus.redirect && m_state != 0) begin
      nxt       = 4;
      last_acc  = cyc;
      m_addr    = bus.redirect_pc;
      m_flushes = (m_flushes < SAT) ? m_flushes + 1 : SAT;
    end else begin
      case (m_state)
        0:       nxt = bus.start ? 1 : 0;
        1:       nxt = bus.fetch_ready ? 2 : 1;
        2, 3:    nxt = s ? 3 : 2;
        4:       nxt = (cyc >= last_acc + FC) ? 1 : 4;
        default: nxt = 0;
      endcase
    end
    m_state = nxt;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asynchronous reset mid-cycle; outputs must take reset values at once.
  task automatic do_reset();
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.fetch_ready = 1'b1; bus.load_use_hazard = 1'b0;
    bus.ext_stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.inst_buffer_full = 1'b0; bus.inst_buffer_empty = 1'b0;
  endtask

  initial begin
    cyc = 0;
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b1;

    // Start: IDLE -> REFILL -> RUN.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("run_after_start", 64'(bus.state), 64'd2);

    // Three-cycle load-use hazard.
    bus.load_use_hazard = 1'b1;
    repeat (3) tick();
    bus.load_use_hazard = 1'b0;
    tick();
    chk("stall_back_run", 64'(bus.state), 64'd2);
    chk("stall_cnt3", 64'(bus.stall_cycles), 64'd3);

    // Redirect to 0x1000.
    bus.redirect = 1'b1; bus.redirect_pc = 64'h1000;
    tick();
    bus.redirect = 1'b0;
    chk("redir_pc_load", 64'(bus.pc_load), 64'd1);
    chk("redir_addr", 64'(bus.pc_load_addr), 64'h1000);
    tick();
    tick();
    chk("redir_refill", 64'(bus.state), 64'd1);
    chk("redir_fcnt1", 64'(bus.flush_count), 64'd1);
    tick();

    // Redirect during the second FLUSH cycle extends the flush.
    bus.redirect = 1'b1; bus.redirect_pc = 64'h1000;
    tick();
    bus.redirect = 1'b0;
    tick();
    bus.redirect = 1'b1; bus.redirect_pc = 64'h2000;
    tick();
    bus.redirect = 1'b0;
    chk("rere_pc_load", 64'(bus.pc_load), 64'd1);
    chk("rere_addr", 64'(bus.pc_load_addr), 64'h2000);
    chk("rere_flush", 64'(bus.id_flush), 64'd1);
    chk("rere_fcnt", 64'(bus.flush_count), 64'd3);
    tick();
    tick();
    chk("rere_refill", 64'(bus.state), 64'd1);
    tick();

    // Redirect together with ext_stall and a full buffer.
    bus.redirect = 1'b1; bus.redirect_pc = 64'h3000;
    bus.ext_stall = 1'b1; bus.inst_buffer_full = 1'b1;
    tick();
    chk("redir_prio_flush", 64'(bus.state), 64'd4);
    bus.redirect = 1'b0; bus.ext_stall = 1'b0; bus.inst_buffer_full = 1'b0;
    tick();

    // Reset in the middle of FLUSH; fetch stays idle until start.
    do_reset();
    repeat (3) tick();
    chk("post_reset_idle", 64'(bus.state), 64'd0);
    chk("post_reset_noload", 64'(bus.pc_load), 64'd0);

    // Random stimulus.
    for (int i = 0; i < 600; i++) begin
      bus.start             = ($urandom_range(0, 2) == 0);
      bus.fetch_ready       = ($urandom_range(0, 3) != 0);
      bus.load_use_hazard   = ($urandom_range(0, 5) == 0);
      bus.ext_stall         = ($urandom_range(0, 5) == 0);
      bus.inst_buffer_full  = ($urandom_range(0, 7) == 0);
      bus.inst_buffer_empty = ($urandom_range(0, 4) == 0);
      bus.redirect          = ($urandom_range(0, 9) == 0);
      bus.redirect_pc       = {$urandom(), $urandom()};
      if (i == 300) do_reset();
      else tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/if_id_pipeline_ctrl.md
# if_id_pipeline_ctrl

Sequencing controller for the IF→ID pipeline boundary. It holds fetch in an idle state after reset, then generates the `pc_stall`, `id_stall`, `id_flush` and PC-redirect controls for the program counter and the IF/ID register. It accounts for hazards, back-pressure and control-flow redirects, and keeps saturating performance counters for stalls and flushes. It sits between the hazard unit / EX-stage branch resolution and the fetch-side registers.

## Interface
- `ADDR_WIDTH`, 64, PC width.
- `FLUSH_CYCLES`, 2, cycles `id_flush` stays asserted per redirect. Must be ≥1.
- `CNT_WIDTH`, 32, width of the performance counters.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin fetching; sampled only in IDLE.
- `fetch_ready`  in  1  fetch data for the current PC is valid this cycle.
- `load_use_hazard`  in  1  hazard unit requests a hold of IF/ID.
- `ext_stall`  in  1  downstream stage back-pressure.
- `redirect`  in  1  taken branch/jump/trap resolved; one-cycle pulse.
- `redirect_pc`  in  ADDR_WIDTH  target PC, valid with `redirect`.
- `inst_buffer_full`  in  1  instruction buffer full.
- `inst_buffer_empty`  in  1  instruction buffer empty.
- `pc_stall`  out  1  hold the PC register.
- `id_stall`  out  1  drives the `stall` input of the IF/ID register.
- `id_flush`  out  1  invalidate IF/ID contents.
- `pc_load`  out  1  load the PC from `pc_load_addr`.
- `pc_load_addr`  out  ADDR_WIDTH  registered redirect target.
- `id_valid`  out  1  the ID stage holds a real instruction.
- `state`  out  3  current FSM state (debug).
- `stall_cycles`  out  CNT_WIDTH  saturating count of cycles in STALL.
- `flush_count`  out  CNT_WIDTH  saturating count of accepted redirects.

## Operation
- States and encodings: IDLE=0, REFILL=1, RUN=2, STALL=3, FLUSH=4. Other encodings go to IDLE.
- Stall term: `S = load_use_hazard | ext_stall | inst_buffer_full | ~fetch_ready`.
- IDLE
  - Outputs: `pc_stall=1`, `id_stall=1`, `id_valid=0`.
  - Transition: `start` → REFILL. `redirect` is ignored.
- REFILL
  - Outputs: `pc_stall=0`, `id_stall=0`, `id_valid=0`.
  - Transition: `fetch_ready` → RUN; otherwise stay.
- RUN and STALL
  - Stall outputs (combinational): `pc_stall = id_stall = S & ~redirect`.
  - `id_valid = ~inst_buffer_empty`.
  - Transitions: RUN with `S` → STALL. STALL with `~S` → RUN.
- Redirect accept: `redirect` seen in REFILL, RUN, STALL or FLUSH.
  - Capture `redirect_pc` into `pc_load_addr`.
  - Load the flush counter with `FLUSH_CYCLES`.
  - Increment `flush_count`.
  - Next state is FLUSH.
  - Redirect takes priority over all stall terms.
- FLUSH
  - Outputs: `id_flush=1`, `pc_stall=0`, `id_stall=0`, `id_valid=0`.
  - `pc_load=1` only in the first FLUSH cycle after each accept.
  - The counter decrements each cycle; at 1 with no new redirect → REFILL.
  - A redirect during FLUSH restarts the sequence with the new target; the latest target wins.
- Counters
  - `stall_cycles` increments on every cycle spent in STALL.
  - Both counters saturate at all-ones; they do not wrap.
- The flush counter is `$clog2(FLUSH_CYCLES+1)` bits wide.

## Timing
- Reset values (asserted asynchronously):
  - `state=IDLE`, `pc_stall=1`, `id_stall=1`.
  - `id_flush=0`, `pc_load=0`, `pc_load_addr=0`, `id_valid=0`.
  - Both counters 0.
- Reset asserted mid-FLUSH or mid-STALL: returns to IDLE immediately, drops any pending `pc_load`, clears counters.
- Stall response: zero-cycle latency (combinational from `S`) in RUN/STALL.
- Redirect response:
  - `redirect` high in cycle N → `pc_load=1` with `pc_load_addr=redirect_pc(N)` in cycle N+1.
  - `id_flush` high in cycles N+1 .. N+FLUSH_CYCLES.
  - REFILL in cycle N+FLUSH_CYCLES+1.
- `redirect` and `S` in the same cycle: stall outputs are 0 and the redirect is accepted.
- `start` and `redirect` together in IDLE: go to REFILL; the redirect is dropped.
- `inst_buffer_full` with `fetch_ready=1`: stall is still asserted (buffer full dominates).

## Test plan
- Reset, then `start` with `fetch_ready=1`:
  - `state` goes 0 → 1 → 2 on consecutive edges.
  - `pc_stall` is 1 during reset and 0 from REFILL on.
- In RUN, hold `load_use_hazard` for 3 cycles:
  - `id_stall=1` in those same 3 cycles.
  - `state=3`, `stall_cycles=3`, back in RUN afterwards.
- In RUN, pulse `redirect` with `redirect_pc=0x1000` (FLUSH_CYCLES=2):
  - Next cycle: `pc_load=1`, `pc_load_addr=0x1000`.
  - `id_flush` high for 2 cycles, then REFILL; `flush_count=1`.
- Second redirect to 0x2000 in the second FLUSH cycle:
  - `pc_load=1` with 0x2000 on the next cycle.
  - `id_flush` is extended by 2 more cycles; `flush_count=2`.
- `redirect` together with `ext_stall=1` and `inst_buffer_full=1`:
  - `id_stall=0` that cycle; FLUSH is entered.
- Assert `reset` low in the middle of FLUSH:
  - All outputs immediately take their reset values.
  - No `pc_load` after release; `start` is required before fetch resumes.
